// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the Memory-stage data-memory responder.
// Holds the FSM encoding, the latched-request record and the address fault rule.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Value driven on rsp_err when an access faults.
  localparam logic RSP_ERR = 1'b1;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  // A byte address faults when it is not word aligned or lies beyond the array.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_width);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit data RAM with per-byte write enables and a registered read port.
// The read register only updates on a read, so its value persists between accesses.
module dmem_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // NOTE: neither the storage nor the read register is reset; RAM macros have no
  // reset port and the consumer masks rdata until a real load has completed.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (en && !we) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data-memory responder: accepts one load/store, waits LATENCY
// cycles, performs the access and holds the response until it is consumed.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  // Out-of-range latencies saturate to the nearest legal bound.
  localparam int unsigned LAT_EFF =
    (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
    (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             err_q, err_d;
  logic             load_ok_q, load_ok_d;

  logic             req_fire;
  logic             access;
  logic             access_err;
  logic             arr_en;
  logic [31:0]      arr_rdata;

  assign req_fire   = req_valid && req_ready;
  assign access     = (state_q == ST_WAIT) && (cnt_q == '0);
  assign access_err = addr_fault(req_q.addr, ADDR_WIDTH);
  // Reset wins over a due access, so an abandoned store never reaches the array.
  assign arr_en     = access && !rst && !access_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      err_q     <= err_d;
      load_ok_q <= load_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_fire)       state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0)    state_d = ST_RESP;
      ST_RESP: if (rsp_ready)      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q;
    req_d     = req_q;
    err_d     = err_q;
    load_ok_d = load_ok_q;
    if (req_fire) begin
      cnt_d       = CNT_LOAD;
      req_d.we    = req_we;
      req_d.addr  = req_addr;
      req_d.wdata = req_wdata;
      req_d.be    = req_be;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // Load data comes straight from the RAM read register; this flag gates it.
    if (access) begin
      err_d     = access_err ? RSP_ERR : 1'b0;
      load_ok_d = !req_q.we && !access_err;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = !rst;
      ST_WAIT: busy = 1'b1;
      ST_RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign rsp_err   = err_q;
  assign rsp_rdata = load_ok_q ? arr_rdata : '0;

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (req_q.we),
    .be   (req_q.be),
    .addr (req_q.addr[ADDR_WIDTH+1:2]),
    .wdata(req_q.wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// reset/backpressure/latency sequences and randomized traffic against a word model.
module tb_dmem_responder;

  localparam int NI    = 3;
  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  function automatic int unsigned lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  logic        clk = 1'b0;
  int          cyc = 0;
  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic        busy      [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(AW),
      .LATENCY   (lat_of(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .busy     (busy[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  // Behavioural memory: byte-addressed rules, per-byte knowledge of contents.
  logic [31:0] model_mem  [NI][WORDS];
  bit   [3:0]  byte_known [NI][WORDS];

  task automatic model_access(input int i, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output logic [31:0] exp_rdata, output logic exp_err,
                              output bit exp_known);
    int unsigned w;
    exp_rdata = '0;
    exp_known = 1'b1;
    exp_err   = ((addr % 4) != 0) || (addr >= 32'(4 * WORDS));
    if (exp_err) return;
    w = addr / 4;
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        model_mem[i][w][8*b +: 8] = wdata[8*b +: 8];
        byte_known[i][w][b]       = 1'b1;
      end
    end
    if (!we) begin
      exp_rdata = model_mem[i][w];
      exp_known = (byte_known[i][w] == 4'hF);
    end
  endtask

  // Caller is at a negedge; returns at the negedge one cycle after the response handshake.
  task automatic run_access(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input int hold,
                            output logic [31:0] rdata, output logic err, output int acc_cyc);
    int n;
    rdata   = '0;
    err     = 1'b0;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    rsp_ready[i] = (hold == 0);
    n = 0;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!req_ready[i]) begin
      timeout_fail("request accept");
      req_valid[i] = 1'b0;
      return;
    end
    @(negedge clk);
    // Junk request held outside IDLE must be ignored.
    req_we[i]    = 1'($urandom_range(0, 1));
    req_addr[i]  = $urandom();
    req_wdata[i] = $urandom();
    req_be[i]    = 4'($urandom_range(0, 15));
    check("busy after accept", busy[i], 1'b1);
    n = 0;
    while (!rsp_valid[i] && n < 100) begin
      check("req_ready low while waiting", req_ready[i], 1'b0);
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[i]) begin
      timeout_fail("response valid");
      req_valid[i] = 1'b0;
      return;
    end
    check("accept-to-response gap", 32'(cyc - acc_cyc), 32'(lat_of(i) + 1));
    check("req_ready low in response", req_ready[i], 1'b0);
    rdata = rsp_rdata[i];
    err   = rsp_err[i];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("backpressure rsp_valid", rsp_valid[i], 1'b1);
      check("backpressure rdata stable", rsp_rdata[i], rdata);
      check("backpressure err stable", rsp_err[i], err);
      check("backpressure busy", busy[i], 1'b1);
      check("backpressure req_ready", req_ready[i], 1'b0);
    end
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    req_valid[i] = 1'b0;
    rsp_ready[i] = 1'b0;
    check("rsp_valid drops after handshake", rsp_valid[i], 1'b0);
    check("busy drops after handshake", busy[i], 1'b0);
    check("idle req_ready after handshake", req_ready[i], 1'b1);
    check("rdata held after handshake", rsp_rdata[i], rdata);
  endtask

  task automatic do_op(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       input string tag, output int acc_cyc);
    logic [31:0] er, ar;
    logic        ee, ae;
    bit          ek;
    model_access(i, we, addr, wdata, be, er, ee, ek);
    run_access(i, we, addr, wdata, be, hold, ar, ae, acc_cyc);
    check({tag, " err"}, ae, ee);
    if (ek) check({tag, " rdata"}, ar, er);
  endtask

  function automatic logic [31:0] pool_addr(input int k);
    return (k == 15) ? 32'hFFC : 32'(((k * 67) % 1023) * 4);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        tbl [$];
    logic [31:0] er, ar, a;
    logic        ee, ae, we;
    logic [3:0]  be;
    bit          ek;
    int          ac, a0, a1, sel, hold, nrand;

    tbl.push_back(vec_t'{we: 1'b1, addr: 32'h10,   wdata: 32'hDEADBEEF, be: 4'hF, exp_rdata: 32'h0,        exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'h10,   wdata: 32'h0,        be: 4'h0, exp_rdata: 32'hDEADBEEF, exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b1, addr: 32'h10,   wdata: 32'h000000AA, be: 4'h1, exp_rdata: 32'h0,        exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'h10,   wdata: 32'h0,        be: 4'h0, exp_rdata: 32'hDEADBEAA, exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b1, addr: 32'h0,    wdata: 32'h11223344, be: 4'hF, exp_rdata: 32'h0,        exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'h12,   wdata: 32'h0,        be: 4'h0, exp_rdata: 32'h0,        exp_err: 1'b1});
    tbl.push_back(vec_t'{we: 1'b1, addr: 32'h1000, wdata: 32'hFFFFFFFF, be: 4'hF, exp_rdata: 32'h0,        exp_err: 1'b1});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'h0,    wdata: 32'h0,        be: 4'h0, exp_rdata: 32'h11223344, exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b1, addr: 32'h10,   wdata: 32'h55555555, be: 4'h0, exp_rdata: 32'h0,        exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'h10,   wdata: 32'h0,        be: 4'h0, exp_rdata: 32'hDEADBEAA, exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b1, addr: 32'h0,    wdata: 32'hAABBCCDD, be: 4'hA, exp_rdata: 32'h0,        exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'h0,    wdata: 32'h0,        be: 4'h0, exp_rdata: 32'hAA22CC44, exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b1, addr: 32'hFFC,  wdata: 32'h89ABCDEF, be: 4'hF, exp_rdata: 32'h0,        exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'hFFC,  wdata: 32'h0,        be: 4'h0, exp_rdata: 32'h89ABCDEF, exp_err: 1'b0});
    tbl.push_back(vec_t'{we: 1'b0, addr: 32'h1003, wdata: 32'h0,        be: 4'h0, exp_rdata: 32'h0,        exp_err: 1'b1});
    tbl.push_back(vec_t'{we: 1'b1, addr: 32'h20,   wdata: 32'hCAFEF00D, be: 4'hF, exp_rdata: 32'h0,        exp_err: 1'b0});

    for (int i = 0; i < NI; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_be[i]    = '0;
      rsp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset req_ready", req_ready[i], 1'b0);
      check("reset rsp_valid", rsp_valid[i], 1'b0);
      check("reset rsp_rdata", rsp_rdata[i], 32'h0);
      check("reset rsp_err",   rsp_err[i],   1'b0);
      check("reset busy",      busy[i],      1'b0);
      rst[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("idle req_ready after reset", req_ready[i], 1'b1);

    // Directed vectors on the LATENCY=2 instance.
    foreach (tbl[k]) begin
      model_access(0, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].be, er, ee, ek);
      run_access(0, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].be, 0, ar, ae, ac);
      check($sformatf("vec%0d rdata", k), ar, tbl[k].exp_rdata);
      check($sformatf("vec%0d err", k), ae, tbl[k].exp_err);
    end

    // Response backpressure for five cycles on a load.
    do_op(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, "backpressure load", ac);

    // Reset while a store to 0x20 is waiting: the store must be abandoned.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h12345678;
    req_be[0]    = 4'hF;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mid-op busy in wait", busy[0], 1'b1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("mid-op reset rsp_valid", rsp_valid[0], 1'b0);
    check("mid-op reset rsp_rdata", rsp_rdata[0], 32'h0);
    check("mid-op reset rsp_err",   rsp_err[0],   1'b0);
    check("mid-op reset busy",      busy[0],      1'b0);
    check("mid-op reset req_ready", req_ready[0], 1'b0);
    @(negedge clk);
    rst[0]       = 1'b0;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", req_ready[0], 1'b1);
    do_op(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "post-reset load 0x20", ac);

    // Latency sweep: back-to-back requests on LATENCY=1 and LATENCY=15.
    for (int i = 1; i < NI; i++) begin
      do_op(i, 1'b1, 32'h40, 32'hA5A5_0000 + 32'(i), 4'hF, 0, "sweep store", a0);
      do_op(i, 1'b0, 32'h40, 32'h0, 4'h0, 0, "sweep load", a1);
      check($sformatf("sweep lat%0d spacing", lat_of(i)), 32'(a1 - a0), 32'(lat_of(i) + 2));
    end

    // Randomized traffic against the model on every instance.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 16; k++) do_op(i, 1'b1, pool_addr(k), $urandom(), 4'hF, 0, "init store", ac);
      nrand = (i == 0) ? 60 : ((i == 1) ? 40 : 12);
      for (int k = 0; k < nrand; k++) begin
        sel = int'($urandom_range(0, 9));
        a   = pool_addr(int'($urandom_range(0, 15)));
        if (sel == 7) a = a | 32'($urandom_range(1, 3));
        else if (sel >= 8) a = a | (32'($urandom_range(1, 20'hFFFFF)) << 12);
        we   = 1'($urandom_range(0, 1));
        be   = 4'($urandom_range(0, 15));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        do_op(i, we, a, $urandom(), be, hold, $sformatf("rand i%0d op%0d", i, k), ac);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the Memory stage of the 5-stage pipeline.
- Accepts one load/store request through a valid/ready handshake and performs it after a programmable number of wait states.
- Returns a response through a second valid/ready handshake.
- Its busy indication lets the hazard logic stall the pipeline while an access is outstanding.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles from request accept to response; legal range 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i writes byte lane i (bits 8i+7:8i).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access faulted.
- busy  out  1  a request is accepted and its response is not yet consumed.

Behaviour:
- Reset
  - When rst is sampled high: state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - req_ready is 0 while rst is high.
  - The memory array is not cleared.
  - Reset in WAIT abandons the access; a pending store is not committed.
  - Reset in RESP drops the response.
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid & req_ready at edge N: latch we, addr, wdata, be; load counter = LATENCY-1; go to WAIT.
  - busy = 1 from the cycle after edge N.
- WAIT
  - req_ready = 0.
  - Counter decrements each cycle.
  - When the counter is 0 at an edge, perform the access at that same edge and go to RESP.
  - Net effect: rsp_valid first high in the cycle after edge N+LATENCY.
- Access, performed at the WAIT->RESP edge
  - err = (latched addr[1:0] != 0) | (latched addr[31:ADDR_WIDTH+2] != 0).
  - Store without err: write the enabled lanes of word addr[ADDR_WIDTH+1:2]; rsp_rdata = 0.
  - Store with be = 0: no array change; valid ack with rsp_err = 0.
  - Load without err: rsp_rdata = the stored word.
  - On err: no array write; rsp_rdata = 0; rsp_err = 1.
- RESP
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake: go to IDLE; rsp_valid and busy drop next cycle; rsp_rdata is held until the next access.
  - req_ready = 0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake.
  - Maximum throughput is one access per LATENCY+2 cycles.
- Request side rules
  - Request inputs are ignored outside IDLE.
  - The initiator holds the request until accepted; the responder does not check stability.
- Read-after-write
  - A load issued after a completed store to the same word returns the merged data.
- Simultaneous events
  - rsp_ready is ignored unless in RESP.
  - rst has priority over every handshake.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - Response error code constant.
  - LATENCY legal-range bounds.
- One sub-module, dmem_array: synchronous single-port 32-bit RAM with 4 byte-lane write enables and registered read, instantiated once.
- FSM, counter and request/response registers live in dmem_responder.

Test Plan:
1. Store then load, LATENCY = 2.
   - Stimulus: store addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at edge 0; rsp_ready held 1; then load addr 0x10.
   - Response: store ack rsp_valid high in the cycle after edge 2, rsp_err = 0; load returns 0xDEADBEEF.
2. Byte-lane merge.
   - Stimulus: word 0x10 holds 0xDEADBEEF; store wdata 0x000000AA, be 4'b0001; then load 0x10.
   - Response: 0xDEADBEAA.
3. Misaligned and out-of-range.
   - Stimulus: load addr 0x12; then store addr 0x0000_1000 (ADDR_WIDTH = 10).
   - Response: both rsp_err = 1, rsp_rdata = 0; a later load of word 0 is unchanged.
4. Response backpressure.
   - Stimulus: hold rsp_ready = 0 for 5 cycles during a load.
   - Response: rsp_valid stays 1 with constant data, req_ready = 0, busy = 1; IDLE is reached one cycle after rsp_ready = 1.
5. Reset mid-operation.
   - Stimulus: assert rst in WAIT of a store to 0x20 (data 0x12345678).
   - Response: next cycle all outputs are at reset values; a later load of 0x20 returns the old contents.
6. LATENCY sweep.
   - Stimulus: LATENCY = 1 and LATENCY = 15 with back-to-back requests.
   - Response: the request-accept to rsp_valid gap equals LATENCY+1 cycles; the second request is accepted only after the first response handshake.
